// File: rtl/sr_latch.sv
// sr_latch -- clocked, bit-sliced SR flag bank.
//
// WIDTH independent cells. Each cell is set by S and cleared by R, and holds
// its value while neither is asserted. Every output is registered, so there is
// exactly one clock of latency from an S/R sample to Q/Qbar/conflict.
//
// Parameters
//   WIDTH          number of cells (1..64)
//   CONFLICT_MODE  S=R=1 policy: 0 NOR-style (Q=Qbar=0, state cleared),
//                  1 set-dominant, 2 reset-dominant, 3 hold.
//                  Any other value behaves as 0.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (Q=0, Qbar=1, conflict=0)
//   S, R      per-bit set / reset requests, sampled every rising edge
//   Q, Qbar   registered value and registered complement
//   conflict  registered; 1 when S and R were both 1 in the previous sample

// One SR cell. The stored bit lives in 'state', separately from q/qbar,
// because a NOR-style conflict drives both outputs low. The following hold
// cycle then rebuilds q/qbar from 'state' without any race.
module sr_cell #(
    parameter int MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qbar,
    output logic conflict
);

    logic state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= 1'b0;
            q        <= 1'b0;
            qbar     <= 1'b1;
            conflict <= 1'b0;
        end else begin
            conflict <= s & r;
            unique case ({s, r})
                2'b00: begin
                    // Hold. The outputs are rebuilt from state, which also
                    // ends a NOR-style Q=Qbar=0 cycle.
                    q    <= state;
                    qbar <= ~state;
                end
                2'b01: begin
                    state <= 1'b0;
                    q     <= 1'b0;
                    qbar  <= 1'b1;
                end
                2'b10: begin
                    state <= 1'b1;
                    q     <= 1'b1;
                    qbar  <= 1'b0;
                end
                default: begin
                    case (MODE)
                        1: begin
                            state <= 1'b1;
                            q     <= 1'b1;
                            qbar  <= 1'b0;
                        end
                        2: begin
                            state <= 1'b0;
                            q     <= 1'b0;
                            qbar  <= 1'b1;
                        end
                        3: begin
                            // Hold: state, q and qbar keep their values.
                        end
                        default: begin
                            state <= 1'b0;
                            q     <= 1'b0;
                            qbar  <= 1'b0;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

module sr_latch #(
    parameter int WIDTH         = 1,
    parameter int CONFLICT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [WIDTH-1:0] conflict
);

    // Out-of-range policies fall back to the NOR-style behaviour.
    localparam int EFF_MODE = (CONFLICT_MODE >= 0 && CONFLICT_MODE <= 3) ? CONFLICT_MODE : 0;

    if (WIDTH < 1) begin : g_bad_width
        $error("sr_latch: WIDTH must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE(EFF_MODE)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .s        (S[i]),
            .r        (R[i]),
            .q        (Q[i]),
            .qbar     (Qbar[i]),
            .conflict (conflict[i])
        );
    end

endmodule

// File: tb/tb_sr_latch.sv
// Directed bench for sr_latch. Instances:
//   u1          WIDTH=1, mode 0
//   g_m[0..3]   WIDTH=4, modes 0..3
//   g_m[4]      WIDTH=4, mode 7 (out of range, expected to act as mode 0)
//   u8          WIDTH=8, mode 0
module tb_sr_latch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic s1, r1, q1, qb1, c1;
    logic [4:0][3:0] s4, r4, q4, qb4, c4;
    logic [7:0] s8, r8, q8, qb8, c8;

    int checks = 0;
    int errors = 0;

    sr_latch #(.WIDTH(1), .CONFLICT_MODE(0)) u1 (
        .clk(clk), .rst(rst), .S(s1), .R(r1), .Q(q1), .Qbar(qb1), .conflict(c1)
    );

    for (genvar g = 0; g < 5; g++) begin : g_m
        sr_latch #(.WIDTH(4), .CONFLICT_MODE(g == 4 ? 7 : g)) u (
            .clk(clk), .rst(rst), .S(s4[g]), .R(r4[g]),
            .Q(q4[g]), .Qbar(qb4[g]), .conflict(c4[g])
        );
    end

    sr_latch #(.WIDTH(8), .CONFLICT_MODE(0)) u8 (
        .clk(clk), .rst(rst), .S(s8), .R(r8), .Q(q8), .Qbar(qb8), .conflict(c8)
    );

    // Advance one rising edge and step 1 time unit past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s1 = 1'b0; r1 = 1'b0;
        s4 = '0;   r4 = '0;
        s8 = '0;   r8 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            checks++;
            if ({q1, qb1, c1} !== 3'b010) begin
                errors++;
                $display("FAIL reset_w1 cyc%0d q/qb/c=%b%b%b want 010", cyc, q1, qb1, c1);
            end
            for (int g = 0; g < 5; g++) begin
                checks++;
                if (q4[g] !== 4'h0 || qb4[g] !== 4'hF || c4[g] !== 4'h0) begin
                    errors++;
                    $display("FAIL reset_w4[%0d] cyc%0d q=%h qb=%h c=%h want 0 f 0",
                             g, cyc, q4[g], qb4[g], c4[g]);
                end
            end
            checks++;
            if (q8 !== 8'h00 || qb8 !== 8'hFF || c8 !== 8'h00) begin
                errors++;
                $display("FAIL reset_w8 cyc%0d q=%h qb=%h c=%h want 00 ff 00", cyc, q8, qb8, c8);
            end
        end
    endtask

    // WIDTH=1: clear, set, then hold; also confirms the outputs do not move
    // until the edge after the request.
    task automatic test_set_clear();
        s1 = 1'b0; r1 = 1'b1;
        tick();
        checks++;
        if ({q1, qb1, c1} !== 3'b010) begin
            errors++;
            $display("FAIL clear q/qb/c=%b%b%b want 010", q1, qb1, c1);
        end
        s1 = 1'b1; r1 = 1'b0;
        #1;
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL latency q=%b before edge, want 0", q1);
        end
        tick();
        checks++;
        if ({q1, qb1, c1} !== 3'b100) begin
            errors++;
            $display("FAIL set q/qb/c=%b%b%b want 100", q1, qb1, c1);
        end
        s1 = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            checks++;
            if ({q1, qb1, c1} !== 3'b100) begin
                errors++;
                $display("FAIL hold_set cyc%0d q/qb/c=%b%b%b want 100", cyc, q1, qb1, c1);
            end
        end
    endtask

    // WIDTH=1 mode 0, starting from Q=1.
    task automatic test_mode0_conflict();
        s1 = 1'b1; r1 = 1'b1;
        tick();
        checks++;
        if ({q1, qb1, c1} !== 3'b001) begin
            errors++;
            $display("FAIL m0_conflict q/qb/c=%b%b%b want 001", q1, qb1, c1);
        end
        s1 = 1'b0; r1 = 1'b0;
        tick();
        checks++;
        if ({q1, qb1, c1} !== 3'b010) begin
            errors++;
            $display("FAIL m0_exit q/qb/c=%b%b%b want 010", q1, qb1, c1);
        end
    endtask

    // All five WIDTH=4 instances see the same stimulus; the expected result
    // per instance is listed in mode order 0,1,2,3,7.
    task automatic test_modes();
        logic [3:0] eq_a  [5] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
        logic [3:0] eqb_a [5] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0};
        logic [3:0] eq_b  [5] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
        logic [3:0] eqb_b [5] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
        // Conflict from Q=0 (all instances are at Q=0 after reset).
        for (int g = 0; g < 5; g++) begin
            s4[g] = 4'hF; r4[g] = 4'hF;
        end
        tick();
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (q4[g] !== eq_a[g] || qb4[g] !== eqb_a[g] || c4[g] !== 4'hF) begin
                errors++;
                $display("FAIL mode_from0[%0d] q=%h qb=%h c=%h want %h %h f",
                         g, q4[g], qb4[g], c4[g], eq_a[g], eqb_a[g]);
            end
        end
        // Set everything, then conflict from Q=1.
        for (int g = 0; g < 5; g++) begin
            s4[g] = 4'hF; r4[g] = 4'h0;
        end
        tick();
        for (int g = 0; g < 5; g++) begin
            s4[g] = 4'hF; r4[g] = 4'hF;
        end
        tick();
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (q4[g] !== eq_b[g] || qb4[g] !== eqb_b[g] || c4[g] !== 4'hF) begin
                errors++;
                $display("FAIL mode_from1[%0d] q=%h qb=%h c=%h want %h %h f",
                         g, q4[g], qb4[g], c4[g], eq_b[g], eqb_b[g]);
            end
        end
        // Release: every mode ends with complementary outputs and no conflict.
        s4 = '0; r4 = '0;
        tick();
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (q4[g] !== eq_b[g] || qb4[g] !== ~eq_b[g] || c4[g] !== 4'h0) begin
                errors++;
                $display("FAIL mode_release[%0d] q=%h qb=%h c=%h want %h %h 0",
                         g, q4[g], qb4[g], c4[g], eq_b[g], ~eq_b[g]);
            end
        end
    endtask

    // WIDTH=8: reset wins over a simultaneous set (and a pending conflict).
    task automatic test_reset_priority();
        s8 = 8'hFF; r8 = 8'h00;
        tick();
        checks++;
        if (q8 !== 8'hFF || qb8 !== 8'h00) begin
            errors++;
            $display("FAIL w8_set q=%h qb=%h want ff 00", q8, qb8);
        end
        rst = 1'b1;
        s8 = 8'hFF; r8 = 8'h0F;
        tick();
        rst = 1'b0;
        checks++;
        if (q8 !== 8'h00 || qb8 !== 8'hFF || c8 !== 8'h00) begin
            errors++;
            $display("FAIL rst_priority q=%h qb=%h c=%h want 00 ff 00", q8, qb8, c8);
        end
        s8 = 8'h00; r8 = 8'h00;
        tick();
        checks++;
        if (q8 !== 8'h00 || qb8 !== 8'hFF || c8 !== 8'h00) begin
            errors++;
            $display("FAIL rst_after q=%h qb=%h c=%h want 00 ff 00", q8, qb8, c8);
        end
    endtask

    // Mode 0, WIDTH=4 from Q=0 with S=1010, R=0110:
    //   bit3 set, bit2 clear, bit1 conflict (Q=Qbar=0), bit0 hold at 0.
    task automatic test_bit_independence();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        s4[0] = 4'b1010; r4[0] = 4'b0110;
        tick();
        checks++;
        if (q4[0] !== 4'b1000 || qb4[0] !== 4'b0101 || c4[0] !== 4'b0010) begin
            errors++;
            $display("FAIL bits_mixed q=%b qb=%b c=%b want 1000 0101 0010", q4[0], qb4[0], c4[0]);
        end
        s4[0] = 4'b0000; r4[0] = 4'b0000;
        tick();
        checks++;
        if (q4[0] !== 4'b1000 || qb4[0] !== 4'b0111 || c4[0] !== 4'b0000) begin
            errors++;
            $display("FAIL bits_release q=%b qb=%b c=%b want 1000 0111 0000", q4[0], qb4[0], c4[0]);
        end
    endtask

    // Single-cycle pulses back to back on WIDTH=8 with different bits.
    task automatic test_back_to_back();
        s8 = 8'h81; r8 = 8'h00;
        tick();
        s8 = 8'h00; r8 = 8'h01;
        tick();
        checks++;
        if (q8 !== 8'h80 || qb8 !== 8'h7F || c8 !== 8'h00) begin
            errors++;
            $display("FAIL pulse_clear q=%h qb=%h c=%h want 80 7f 00", q8, qb8, c8);
        end
        s8 = 8'h3C; r8 = 8'h00;
        tick();
        s8 = 8'h00;
        repeat (4) tick();
        checks++;
        if (q8 !== 8'hBC || qb8 !== 8'h43 || c8 !== 8'h00) begin
            errors++;
            $display("FAIL pulse_persist q=%h qb=%h c=%h want bc 43 00", q8, qb8, c8);
        end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_mode0_conflict();
        test_modes();
        test_reset_priority();
        test_bit_independence();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
